// File: rtl/debounce_pkg.sv
// Shared constants and filter state encoding for the multi-channel debouncer.
package debounce_pkg;

  localparam int unsigned TICK_DIV_100M  = 250000;
  localparam int unsigned DEF_STABLE_CNT = 4;

  // The state bit is the accepted level itself.
  typedef enum logic {
    IDLE0 = 1'b0,
    IDLE1 = 1'b1
  } state_e;

  // Counter width for a range 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: synchroniser, optional inversion, tick-driven
// stability filter and registered press/release pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned      CW      = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]    CNT_MAX = CW'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchroniser shift chain; the pad enters at bit 0.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Filter state, stability counter and edge pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: count differing ticks, toggle after STABLE_CNT in a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (s == (state_q == IDLE1)) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        state_d = (state_q == IDLE1) ? IDLE0 : IDLE1;
        rise_d  = (state_q == IDLE0);
        fall_d  = (state_q == IDLE1);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    level_o = (state_q == IDLE1);
    rise_o  = rise_q;
    fall_o  = fall_q;
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: shared sample tick plus N_CH
// independent debounce channels.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TICK_DIV    = TICK_DIV_100M,
  parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic            tick
);

  localparam int unsigned   TW   = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick_q;

  // Free-running sample counter 0..TICK_DIV-1.
  always_comb begin
    tcnt_d = (tcnt_q == TMAX) ? '0 : tcnt_q + 1'b1;
  end

  // tick is registered from the next count so it is high exactly while
  // tcnt sits at TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tick_q <= (tcnt_d == TMAX);
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT  (STABLE_CNT),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_in[g]),
      .tick_i  (tick_q),
      .level_o (btn_level[g]),
      .rise_o  (btn_rise[g]),
      .fall_o  (btn_fall[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with N_CH=2, TICK_DIV=4, STABLE_CNT=3.
// Cycle 0 is the first cycle with rst low; ticks fall on cycles 3,7,11,...
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int unsigned rcnt [2];
  int unsigned fcnt [2];

  debounce_multi #(
    .N_CH        (2),
    .TICK_DIV    (4),
    .STABLE_CNT  (3),
    .SYNC_STAGES (2),
    .ACTIVE_LOW  (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rcnt[0] = 0; rcnt[1] = 0; fcnt[0] = 0; fcnt[1] = 0;
  end

  // Pulse tallies sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (btn_rise[i] === 1'b1) rcnt[i] = rcnt[i] + 1;
      if (btn_fall[i] === 1'b1) fcnt[i] = fcnt[i] + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 2'b11;

    // Reset held for 5 cycles with both buttons pressed.
    repeat (3) step();
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_rise",  32'(btn_rise),  32'h0);
    check("rst_fall",  32'(btn_fall),  32'h0);
    check("rst_tick",  32'(tick),      32'h0);
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;

    // Held press is reported only after three ticks, never at reset exit.
    for (int c = 0; c < 12; c++) begin
      goto(c);
      check("exit_level", 32'(btn_level), 32'h0);
      check("exit_rise",  32'(btn_rise),  32'h0);
      check("exit_tick",  32'(tick),      (c % 4 == 3) ? 32'h1 : 32'h0);
    end
    goto(12);
    check("exit_level_acc", 32'(btn_level), 32'h3);
    check("exit_rise_acc",  32'(btn_rise),  32'h3);
    goto(13);
    check("exit_rise_end",  32'(btn_rise),  32'h0);
    check("exit_rcnt0",     32'(rcnt[0]),   32'd1);
    check("exit_rcnt1",     32'(rcnt[1]),   32'd1);
    btn_in = 2'b00;

    // Release both: s=0 from 15, ticks 15/19/23, fall in 24.
    goto(24);
    check("rel_level", 32'(btn_level), 32'h0);
    check("rel_fall",  32'(btn_fall),  32'h3);
    goto(25);
    check("rel_fall_end", 32'(btn_fall), 32'h0);

    // Glitch: ch0 high for cycles 28..33, seen on ticks 31 and 35 only.
    goto(28);
    btn_in = 2'b01;
    goto(34);
    btn_in = 2'b00;
    goto(40);
    check("glitch_level", 32'(btn_level), 32'h0);
    check("glitch_rcnt0", 32'(rcnt[0]),   32'd1);
    check("glitch_fcnt0", 32'(fcnt[0]),   32'd1);

    // Clean press right after tick 39: ticks 43/47/51, level in 52.
    btn_in = 2'b01;
    goto(51);
    check("press_level_pre", 32'(btn_level), 32'h0);
    goto(52);
    check("press_level", 32'(btn_level), 32'h1);
    check("press_rise",  32'(btn_rise),  32'h1);
    goto(53);
    check("press_rise_end", 32'(btn_rise), 32'h0);
    check("press_rcnt0",    32'(rcnt[0]),  32'd2);
    check("press_rcnt1",    32'(rcnt[1]),  32'd1);

    // Bounce train on ch1: 3 high / 3 low for 40 cycles, settle high at 94.
    for (int k = 0; k < 40; k++) begin
      goto(54 + k);
      btn_in = {((k / 3) % 2 == 0) ? 1'b1 : 1'b0, 1'b1};
    end
    goto(94);
    btn_in = 2'b11;
    goto(107);
    check("bounce_level_pre", 32'(btn_level), 32'h1);
    check("bounce_rcnt1_pre", 32'(rcnt[1]),   32'd1);
    goto(108);
    check("bounce_level", 32'(btn_level), 32'h3);
    check("bounce_rise",  32'(btn_rise),  32'h2);
    goto(109);
    check("bounce_rise_end", 32'(btn_rise), 32'h0);
    check("bounce_rcnt1",    32'(rcnt[1]),  32'd2);
    check("bounce_fcnt1",    32'(fcnt[1]),  32'd1);

    // Simultaneous release: ticks 115/119/123, falls together in 124.
    goto(110);
    btn_in = 2'b00;
    goto(123);
    check("srel_level_pre", 32'(btn_level), 32'h3);
    check("srel_fall_pre",  32'(btn_fall),  32'h0);
    goto(124);
    check("srel_fall",  32'(btn_fall),  32'h3);
    check("srel_level", 32'(btn_level), 32'h0);
    goto(125);
    check("srel_fall_end", 32'(btn_fall), 32'h0);
    check("srel_fcnt0",    32'(fcnt[0]),  32'd2);
    check("srel_fcnt1",    32'(fcnt[1]),  32'd2);

    // Reset after ticks 127 and 131 of a ch0 press; count must restart.
    btn_in = 2'b01;
    goto(132);
    rst = 1'b1;
    goto(133);
    check("mid_rst_level", 32'(btn_level), 32'h0);
    check("mid_rst_tick",  32'(tick),      32'h0);
    goto(134);
    rst = 1'b0;
    goto(136);
    check("mid_tick_phase0", 32'(tick), 32'h0);
    goto(137);
    check("mid_tick_phase1", 32'(tick), 32'h1);
    goto(145);
    check("mid_level_pre", 32'(btn_level), 32'h0);
    check("mid_rise_pre",  32'(btn_rise),  32'h0);
    goto(146);
    check("mid_level", 32'(btn_level), 32'h1);
    check("mid_rise",  32'(btn_rise),  32'h1);
    goto(147);
    check("mid_rise_end", 32'(btn_rise), 32'h0);
    check("mid_rcnt0",    32'(rcnt[0]),  32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel push-button/switch conditioner for the board front panel, the next generation of the single-button debouncer. Every channel gets a synchroniser, a counter-based stability filter driven by a shared sample-tick enable, and one-cycle press/release pulses. The whole block runs in the system clock domain with no derived clocks. Its outputs feed the processor's step/run/reset control and the display mode selects.

## Interface
- N_CH, 4: number of independent input channels.
- TICK_DIV, 250000: sample period in clk cycles. Legal range is ≥1; 250000 gives 2.5 ms at 100 MHz.
- STABLE_CNT, 4: number of consecutive differing samples required to accept a new level. Legal range is ≥1.
- SYNC_STAGES, 2: synchroniser flops per channel. Legal range is ≥2.
- ACTIVE_LOW, 0: when 1, inputs are inverted after synchronisation, so a pressed button always reads as 1.
- clk  input  1  system clock (100 MHz).
- rst  input  1  reset, synchronous, active-high.
- btn_in  input  N_CH  raw asynchronous pad inputs.
- btn_level  output  N_CH  debounced level, 1 = pressed.
- btn_rise  output  N_CH  one-clk pulse when btn_level goes 0→1.
- btn_fall  output  N_CH  one-clk pulse when btn_level goes 1→0.
- tick  output  1  shared sample enable, exported for debug and test.

## Operation
- **Synchroniser:** SYNC_STAGES flops per channel, clocked on clk. Inversion by ACTIVE_LOW follows the last stage, giving signal s[i].
- **Tick generator:** counter tcnt runs 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly the one cycle in which tcnt == TICK_DIV-1.
  - With TICK_DIV=1, tick is constantly 1.
- **Per-channel filter:** two-state FSM with states IDLE0 (level 0) and IDLE1 (level 1), plus counter cnt[i].
  - In cycles where tick = 0, nothing changes.
  - On a tick cycle where s[i] == level[i], cnt[i] is cleared to 0.
  - On a tick cycle where s[i] != level[i] and cnt[i] == STABLE_CNT-1:
    - level[i] toggles;
    - cnt[i] is cleared to 0;
    - rise[i] or fall[i] is registered high.
  - On a tick cycle where s[i] != level[i] otherwise, cnt[i] increments.
  - rise[i] and fall[i] are cleared in every cycle in which they are not being set. They are never high together.
- **Width rules:**
  - tcnt is $clog2(TICK_DIV) bits, with a minimum of 1.
  - cnt is $clog2(STABLE_CNT) bits, with a minimum of 1.
  - cnt saturates by construction and never exceeds STABLE_CNT-1.
- **Glitch rejection:** a disturbance sampled as differing on fewer than STABLE_CNT consecutive ticks causes no output change, and the counter restarts from 0.
- **Channel independence:** channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- **Reset values:** rst clears all synchroniser flops, tcnt, every cnt, btn_level, btn_rise, btn_fall and tick to 0.
  - A reset asserted mid-count discards partial counts.
  - No pulse is generated on reset exit, even if an input is already held pressed. That press is reported as a rise after the normal latency.

## Timing
- btn_level, btn_rise, btn_fall and tick are all registered outputs; there are no combinational paths from btn_in.
- **Input latency:** a clean step on btn_in reaches s[i] SYNC_STAGES cycles later.
- **Acceptance:** the level is accepted on the STABLE_CNT-th tick that samples the new value.
- **Output timing:** btn_level changes, and the matching rise/fall pulse is high, in the cycle following that tick cycle. The pulse lasts exactly 1 clk.
- **Worst-case latency:** SYNC_STAGES + STABLE_CNT·TICK_DIV + 1 cycles.
- **Minimum accepted pulse width:** (STABLE_CNT-1)·TICK_DIV + 1 cycles.
- **Tick phase:** the first tick after reset deassertion occurs in cycle TICK_DIV-1, counting the first cycle with rst = 0 as cycle 0.

## Structure
- Package debounce_pkg holds the default constants (TICK_DIV_100M = 250000, DEF_STABLE_CNT = 4) and the FSM state encoding (IDLE0 = 1'b0, IDLE1 = 1'b1). The state bit is the level itself.
- Sub-module debounce_chan contains one channel's synchroniser, inversion, filter and edge registers. It takes tick as an input.
- The top level holds only the shared tick generator and a generate loop of N_CH debounce_chan instances.
- Target size is about 150–200 lines of RTL.

## Test plan
Bench parameters: N_CH=2, TICK_DIV=4, STABLE_CNT=3, SYNC_STAGES=2, ACTIVE_LOW=0.
- **Reset state:** hold rst for 5 cycles with btn_in = 2'b11. All outputs are 0 during reset. After reset, btn_level becomes 2'b11 and exactly one btn_rise pulse occurs per channel; no pulse occurs at reset exit.
- **Clean press:** btn_in[0] goes 0→1 right after a tick. btn_level[0] rises within ≤ 2+12+1 = 15 cycles. btn_rise[0] is high for exactly 1 cycle, and channel 1 is unaffected.
- **Glitch rejection:** btn_in[0] goes high for 6 cycles (sampled on ≤2 ticks), then low. There is no change on btn_level or any pulse, and cnt returns to 0.
- **Bounce train:** btn_in[1] toggles every 3 cycles for 40 cycles, then settles high. Exactly one btn_rise[1] occurs, after settling, and no btn_fall[1] occurs.
- **Simultaneous release:** both channels are pressed and accepted, then both released in the same cycle. btn_fall = 2'b11 is asserted in the same single cycle.
- **Reset mid-count:** assert rst after 2 accepted-direction ticks of a press. After release of reset, with the input still high, acceptance takes a full 3 ticks from scratch.
